// File: rtl/param_johnson_ring_counter.sv
// Parametrised shift-register sequencer: Johnson (period 2*WIDTH) or one-hot ring (period WIDTH),
// with enable, direction, parallel load, step decode, wrap pulse and illegal-state self-correction.
module param_johnson_ring_counter #(
    parameter int WIDTH = 4,
    parameter int SW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] dout,
    output logic [SW-1:0]    step,
    output logic             tc,
    output logic             illegal,
    output logic             corr
);

    typedef enum logic {
        MODE_JOHNSON = 1'b0,
        MODE_RING    = 1'b1
    } mode_e;

    mode_e            mode_q, mode_d, mode_in;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] shifted;
    logic             tc_q, tc_d;
    logic             corr_q, corr_d;
    logic             legal;
    logic             j_lsb_run, j_msb_run, ring_one;
    logic [WIDTH-1:0] inv;
    logic [SW-1:0]    pc, ring_idx;

    function automatic logic [WIDTH-1:0] start_of(input mode_e m);
        return (m == MODE_RING) ? WIDTH'(1) : '0;
    endfunction

    assign mode_in = mode_e'(mode);
    assign inv     = ~dout_q;

    // x & (x+1) == 0 exactly when x is a (possibly empty) LSB-aligned run of ones
    assign j_lsb_run = ((dout_q & (dout_q + WIDTH'(1))) == '0);
    assign j_msb_run = ((inv & (inv + WIDTH'(1))) == '0);
    assign ring_one  = (dout_q != '0) && ((dout_q & (dout_q - WIDTH'(1))) == '0);
    assign legal     = (mode_q == MODE_RING) ? ring_one : (j_lsb_run || j_msb_run);

    always_comb begin
        pc       = '0;
        ring_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pc = pc + SW'(dout_q[i]);
            if (dout_q[i]) begin
                ring_idx = SW'(i);
            end
        end
    end

    always_comb begin
        step = '0;
        if (legal) begin
            if (mode_q == MODE_RING) begin
                step = ring_idx;
            end else if (dout_q[0] || (dout_q == '0)) begin
                step = pc;
            end else begin
                // modulo-2^SW subtraction yields 2*WIDTH - popcount even when 2*WIDTH == 2^SW
                step = SW'(2 * WIDTH) - pc;
            end
        end
    end

    always_comb begin
        shifted = dout_q;
        case ({mode_q == MODE_RING, dir})
            2'b00:   shifted = {dout_q[WIDTH-2:0], ~dout_q[WIDTH-1]};
            2'b01:   shifted = {~dout_q[0], dout_q[WIDTH-1:1]};
            2'b10:   shifted = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
            default: shifted = {dout_q[0], dout_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        dout_d = dout_q;
        mode_d = mode_q;
        tc_d   = 1'b0;
        corr_d = 1'b0;
        if (rst) begin
            dout_d = start_of(mode_in);
            mode_d = mode_in;
        end else if (mode_in != mode_q) begin
            dout_d = start_of(mode_in);
            mode_d = mode_in;
        end else if (load) begin
            dout_d = load_data;
        end else if (en) begin
            if (legal) begin
                dout_d = shifted;
                tc_d   = (shifted == start_of(mode_q));
            end else begin
                dout_d = start_of(mode_q);
                corr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        dout_q <= dout_d;
        mode_q <= mode_d;
        tc_q   <= tc_d;
        corr_q <= corr_d;
    end

    assign dout    = dout_q;
    assign tc      = tc_q;
    assign corr    = corr_q;
    assign illegal = ~legal;

endmodule
